spi_arb_ctrl: RTL
=================

SPI_ARB_CTRL -- requirements
Module: spi_arb_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one spi_m master.
REQ-002 Parameter SETUP_CYC, default 2: cycles from ss_n assertion to first m_start.
REQ-003 Parameter TEAR_CYC, default 2: cycles ss_n is held high after a burst before the next grant.
REQ-004 Parameter TMO_CYC, default 255: cycles the owner may withhold req_valid mid-burst before the burst is aborted.
REQ-005 Ports SHALL be: clk in 1, the single clock; rst in 1, asynchronous active-low reset.
REQ-006 req_valid in NREQ, per-requester byte-available; req_data in NREQ*8, packed bytes; req_last in NREQ, byte ends the burst.
REQ-007 req_ack out NREQ, one-cycle pulse when the owner's byte is consumed.
REQ-008 rsp_valid out 1, one-cycle received-byte strobe; rsp_data out 8; rsp_id out clog2(NREQ), owner index.
REQ-009 cfg_dvsr in NREQ*16; cfg_cpol in NREQ; cfg_cpha in NREQ: per-requester SPI mode and clock divider.
REQ-010 ss_n out NREQ, active-low slave selects; busy out 1, high while any grant is held; err out 1, one-cycle timeout pulse.
REQ-011 Master side: m_start out 1; m_din out 8; m_dvsr out 16; m_cpol out 1; m_cpha out 1; m_ready in 1; m_done in 1; m_dout in 8.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, START, BUSY, TEAR.
REQ-013 IDLE: when any req_valid is high, grant SHALL go round-robin, searching from (last_owner+1) mod NREQ; after reset last_owner = NREQ-1, so requester 0 has first priority; next state SETUP.
REQ-014 On grant: latch owner; drive m_cpol/m_cpha/m_dvsr from the owner's cfg slice, held constant until TEAR exits; assert ss_n[owner]=0 on SETUP entry.
REQ-015 SETUP lasts exactly SETUP_CYC cycles, then START.
REQ-016 START: when m_ready=1 and req_valid[owner]=1, pulse m_start and req_ack[owner] for one cycle, m_din=req_data[owner], latch req_last[owner]; next state BUSY.
REQ-017 BUSY: on m_done=1, the next cycle SHALL carry rsp_valid=1, rsp_data=m_dout captured, rsp_id=owner; next state TEAR if the latched last=1, else START.
REQ-018 In START, a timeout counter SHALL count cycles with req_valid[owner]=0; reaching TMO_CYC pulses err, skips the byte, and goes to TEAR.
REQ-019 TEAR: ss_n all high on entry, held TEAR_CYC cycles; update last_owner, then IDLE.
REQ-020 Exactly one ss_n bit is low from SETUP through BUSY; none in IDLE or TEAR.
REQ-021 Non-owner req_valid changes SHALL NOT affect the current burst; they are arbitrated only in IDLE.
REQ-022 cfg changes during a grant SHALL be ignored until the next grant.
REQ-023 m_done arriving outside BUSY SHALL be ignored.
REQ-024 busy = 1 in SETUP, START, BUSY and TEAR.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, ss_n all 1, m_start 0, m_din 0, m_dvsr 0, m_cpol 0, m_cpha 0, req_ack 0, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, err 0, counters 0, last_owner NREQ-1.
REQ-026 Reset mid-burst SHALL abort without rsp_valid; the spi_m is reset by the same rst.

Structure
REQ-027 Package spi_arb_pkg SHALL hold the state enum and default values for NREQ, SETUP_CYC, TEAR_CYC and TMO_CYC.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, last_owner in; one-hot grant and index out); the FSM, counters and muxing live in spi_arb_ctrl.

Verification
REQ-029 Single byte: req 0 with data 8'h64, last=1, dvsr 49, miso looped to mosi -> ss_n=4'b1110 for 2 cycles, one m_start, rsp_data 8'h64 with rsp_id 0, ss_n high for 2 cycles.
REQ-030 Burst: req 2 sends 8'hA5, 8'h3C, last on the second -> ss_n[2] stays low across both bytes, two req_ack pulses, and two rsp_valid pulses with rsp_id 2.
REQ-031 Contention: reqs 0, 1 and 3 all valid from reset with single-byte bursts -> grants in order 0, 1, 3, 0, and ss_n never has two bits low.
REQ-032 Modes: cfg_cpol/cpha for requester 1 = 1/1, requester 0 = 0/0 -> m_cpol/m_cpha switch only in IDLE, and are stable before the ss_n fall.
REQ-033 Timeout: req 1 sends a byte with last=0, then drops valid for 255 cycles -> err pulse, ss_n[1] returns high, next grant proceeds normally.
REQ-034 Reset mid-BUSY: rst=0 during an active transfer -> all outputs at reset values in the same cycle, and no rsp_valid afterwards.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and default parameters for the SPI master arbiter.
package spi_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int SETUP_CYC_DEF = 2;
    localparam int TEAR_CYC_DEF  = 2;
    localparam int TMO_CYC_DEF   = 255;

    // One counter serves SETUP, TEAR and the START timeout.
    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = 16'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        BUSY  = 3'd3,
        TEAR  = 3'd4
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arb_rr_arbiter.sv
// Round-robin selector: first asserted request after last_owner, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan the NREQ positions starting just after the previous owner.
    always_comb begin
        grant_o     = {NREQ{1'b0}};
        grant_idx_o = {IDX_W{1'b0}};
        found_s     = 1'b0;
        cand_s      = {IDX_W{1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = IDX_W'((int'(last_owner_i) + i) % NREQ);
            if (!found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_idx_o     = cand_s;
                grant_o[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        grant_vld_o = found_s;
    end

endmodule

// File: rtl/spi_arb_ctrl.sv
// Arbitrates NREQ byte streams onto one SPI master: grant, select, transfer, release.
module spi_arb_ctrl
    import spi_arb_pkg::*;
#(
    parameter  int NREQ      = NREQ_DEF,
    parameter  int SETUP_CYC = SETUP_CYC_DEF,
    parameter  int TEAR_CYC  = TEAR_CYC_DEF,
    parameter  int TMO_CYC   = TMO_CYC_DEF,
    localparam int IDX_W     = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*8-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ack,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_data,
    output logic [IDX_W-1:0]     rsp_id,
    input  logic [NREQ*16-1:0]   cfg_dvsr,
    input  logic [NREQ-1:0]      cfg_cpol,
    input  logic [NREQ-1:0]      cfg_cpha,
    output logic [NREQ-1:0]      ss_n,
    output logic                 busy,
    output logic                 err,
    output logic                 m_start,
    output logic [7:0]           m_din,
    output logic [15:0]          m_dvsr,
    output logic                 m_cpol,
    output logic                 m_cpha,
    input  logic                 m_ready,
    input  logic                 m_done,
    input  logic [7:0]           m_dout
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] TEAR_LAST  = CNT_W'(TEAR_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CYC - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [NREQ-1:0]  owner_oh_q, owner_oh_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [NREQ-1:0]  ss_n_q, ss_n_d;
    logic [15:0]      dvsr_q, dvsr_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [IDX_W-1:0] rsp_id_q, rsp_id_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             m_start_s;
    logic [NREQ-1:0]  gnt_oh_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             gnt_vld_s;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i        (req_valid),
        .last_owner_i (last_owner_q),
        .grant_o      (gnt_oh_s),
        .grant_idx_o  (gnt_idx_s),
        .grant_vld_o  (gnt_vld_s)
    );

    // State register plus every registered output and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= {IDX_W{1'b0}};
            owner_oh_q   <= {NREQ{1'b0}};
            last_owner_q <= IDX_W'(NREQ - 1);
            cnt_q        <= {CNT_W{1'b0}};
            last_q       <= 1'b0;
            ss_n_q       <= {NREQ{1'b1}};
            dvsr_q       <= 16'h0000;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_id_q     <= {IDX_W{1'b0}};
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            owner_oh_q   <= owner_oh_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            ss_n_q       <= ss_n_d;
            dvsr_q       <= dvsr_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; m_start is decoded in START so the handshake takes one cycle.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        owner_oh_d   = owner_oh_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        ss_n_d       = ss_n_q;
        dvsr_d       = dvsr_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        err_d        = 1'b0;
        m_start_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld_s) begin
                    owner_d    = gnt_idx_s;
                    owner_oh_d = gnt_oh_s;
                    ss_n_d     = ~gnt_oh_s;
                    dvsr_d     = cfg_dvsr[{gnt_idx_s, 4'b0000} +: 16];
                    cpol_d     = cfg_cpol[gnt_idx_s];
                    cpha_d     = cfg_cpha[gnt_idx_s];
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            START: begin
                if (req_valid[owner_q]) begin
                    if (m_ready) begin
                        m_start_s = 1'b1;
                        last_d    = req_last[owner_q];
                        cnt_d     = {CNT_W{1'b0}};
                        state_d   = BUSY;
                    end else begin
                        state_d = START;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    // Owner went silent mid-burst: drop the byte slot and release the bus.
                    err_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    ss_n_d  = {NREQ{1'b1}};
                    state_d = TEAR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BUSY: begin
                if (m_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = m_dout;
                    rsp_id_d    = owner_q;
                    if (last_q) begin
                        ss_n_d  = {NREQ{1'b1}};
                        state_d = TEAR;
                    end else begin
                        state_d = START;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            TEAR: begin
                if (cnt_q == TEAR_LAST) begin
                    cnt_d        = {CNT_W{1'b0}};
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                ss_n_d  = {NREQ{1'b1}};
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign req_ack   = m_start_s ? owner_oh_q : {NREQ{1'b0}};
    assign m_start   = m_start_s;
    assign m_din     = m_start_s ? req_data[{owner_q, 3'b000} +: 8] : 8'h00;
    assign m_dvsr    = dvsr_q;
    assign m_cpol    = cpol_q;
    assign m_cpha    = cpha_q;
    assign ss_n      = ss_n_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule
